// File: rtl/pipe_hazard_ctrl.sv
// Hazard/interlock controller for the in-order pipeline. It tracks in-flight destination tags
// and produces stall, bubble, flush, kill and forwarding-select controls plus perf counters.
module pipe_hazard_ctrl #(
    parameter int DEPTH         = 3,
    parameter int RA_W          = 5,
    parameter int FWD_EN        = 1,
    parameter int LOAD_LAT      = 1,
    parameter int RESOLVE_STAGE = 3,
    parameter int RF_WB_BYPASS  = 0,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RA_W-1:0]  id_wr,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             redirect_valid,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic [DEPTH-1:0] kill_mask,
    output logic [3:0]       fwd_sel_a,
    output logic [3:0]       fwd_sel_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Slots younger than the resolving slot are on the wrong path after a redirect.
    localparam logic [DEPTH-1:0] KILL_PATTERN = DEPTH'((1 << (RESOLVE_STAGE - 1)) - 1);

    // Index k-1 of each tag vector/array holds back-end slot k.
    logic [DEPTH-1:0] tagV_q, tagV_d;
    logic [DEPTH-1:0] tagWe_q, tagWe_d;
    logic [DEPTH-1:0] tagLd_q, tagLd_d;
    logic [RA_W-1:0]  tagWr_q [DEPTH];
    logic [RA_W-1:0]  tagWr_d [DEPTH];

    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    logic [RA_W-1:0]  opRs [2];
    logic [1:0]       opUsed;
    logic [DEPTH-1:0] opMatch [2];
    logic [1:0]       opFound;
    logic [1:0]       opYoungLd;
    logic [3:0]       opYoungSlot [2];
    logic [1:0]       opHazard;
    logic [3:0]       opSel [2];

    logic hazard;
    logic issue;

    assign opRs[0]   = id_rs1;
    assign opRs[1]   = id_rs2;
    assign opUsed[0] = id_rs1_used;
    assign opUsed[1] = id_rs2_used;

    // Per-operand match scan; descending loop leaves the youngest (smallest slot) match.
    always_comb begin
        for (int op = 0; op < 2; op++) begin
            opMatch[op]     = '0;
            opFound[op]     = 1'b0;
            opYoungLd[op]   = 1'b0;
            opYoungSlot[op] = 4'd0;
            opHazard[op]    = 1'b0;
            opSel[op]       = 4'd0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                opMatch[op][k] = opUsed[op] && (opRs[op] != '0) && tagV_q[k] && tagWe_q[k]
                                 && (tagWr_q[k] == opRs[op]);
                if (opMatch[op][k]) begin
                    opFound[op]     = 1'b1;
                    opYoungLd[op]   = tagLd_q[k];
                    opYoungSlot[op] = 4'(k + 1);
                end
            end
            if (FWD_EN != 0) begin
                if (opFound[op]) begin
                    if (opYoungLd[op] && (opYoungSlot[op] <= 4'(LOAD_LAT))) begin
                        opHazard[op] = 1'b1;
                    end else if ((opYoungSlot[op] == 4'(DEPTH)) && (RF_WB_BYPASS != 0)) begin
                        opSel[op] = 4'd0;
                    end else begin
                        opSel[op] = opYoungSlot[op];
                    end
                end
            end else begin
                opHazard[op] = (|opMatch[op][DEPTH-2:0])
                               || (opMatch[op][DEPTH-1] && (RF_WB_BYPASS == 0));
            end
        end
    end

    // A redirect squashes the ID instruction anyway, so it overrides any stall.
    always_comb begin
        hazard      = id_valid && (opHazard[0] || opHazard[1]);
        stall_if_id = hazard && !redirect_valid;
        bubble_ex   = stall_if_id || redirect_valid;
        flush_if_id = redirect_valid;
        kill_mask   = redirect_valid ? KILL_PATTERN : '0;
        fwd_sel_a   = opSel[0];
        fwd_sel_b   = opSel[1];
        issue       = id_valid && !stall_if_id && !redirect_valid;
    end

    // Back-end slots always advance; kills apply to the post-shift position.
    always_comb begin
        tagV_d[0]  = issue && !kill_mask[0];
        tagWe_d[0] = id_we;
        tagLd_d[0] = id_is_load;
        tagWr_d[0] = id_wr;
        for (int k = 1; k < DEPTH; k++) begin
            tagV_d[k]  = tagV_q[k-1] && !kill_mask[k];
            tagWe_d[k] = tagWe_q[k-1];
            tagLd_d[k] = tagLd_q[k-1];
            tagWr_d[k] = tagWr_q[k-1];
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (stall_if_id && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
        if (redirect_valid && (flushCnt_q != '1)) begin
            flushCnt_d = flushCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tagV_q     <= '0;
            tagWe_q    <= '0;
            tagLd_q    <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tagWr_q[k] <= '0;
            end
        end else begin
            tagV_q     <= tagV_d;
            tagWe_q    <= tagWe_d;
            tagLd_q    <= tagLd_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                tagWr_q[k] <= tagWr_d[k];
            end
        end
    end

    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: four parameterisations share one ID/redirect stimulus
// stream, and each scenario checks only the instances it targets.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       idValid;
    logic [4:0] idRs1, idRs2, idWr;
    logic       idRs1Used, idRs2Used, idWe, idIsLoad;
    logic       redirectValid;

    int errors = 0;
    int checks = 0;

    // A: forwarding defaults; B: interlock, no WB bypass; C: interlock with WB bypass;
    // D: interlock with 4-bit counters for saturation.
    logic        stallA, bubbleA, flushA;
    logic [2:0]  killA;
    logic [3:0]  selAA, selBA;
    logic [31:0] stallCntA, flushCntA;
    logic        stallB, bubbleB, flushB;
    logic [2:0]  killB;
    logic [3:0]  selAB, selBB;
    logic [31:0] stallCntB, flushCntB;
    logic        stallC, bubbleC, flushC;
    logic [2:0]  killC;
    logic [3:0]  selAC, selBC;
    logic [31:0] stallCntC, flushCntC;
    logic        stallD, bubbleD, flushD;
    logic [2:0]  killD;
    logic [3:0]  selAD, selBD;
    logic [3:0]  stallCntD, flushCntD;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DEPTH(3), .RA_W(5), .FWD_EN(1), .LOAD_LAT(1), .RESOLVE_STAGE(3),
                       .RF_WB_BYPASS(0), .CNT_W(32)) dutA (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
        .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used), .id_wr(idWr), .id_we(idWe),
        .id_is_load(idIsLoad), .redirect_valid(redirectValid), .stall_if_id(stallA),
        .bubble_ex(bubbleA), .flush_if_id(flushA), .kill_mask(killA), .fwd_sel_a(selAA),
        .fwd_sel_b(selBA), .stall_cnt(stallCntA), .flush_cnt(flushCntA));

    pipe_hazard_ctrl #(.DEPTH(3), .RA_W(5), .FWD_EN(0), .LOAD_LAT(1), .RESOLVE_STAGE(3),
                       .RF_WB_BYPASS(0), .CNT_W(32)) dutB (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
        .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used), .id_wr(idWr), .id_we(idWe),
        .id_is_load(idIsLoad), .redirect_valid(redirectValid), .stall_if_id(stallB),
        .bubble_ex(bubbleB), .flush_if_id(flushB), .kill_mask(killB), .fwd_sel_a(selAB),
        .fwd_sel_b(selBB), .stall_cnt(stallCntB), .flush_cnt(flushCntB));

    pipe_hazard_ctrl #(.DEPTH(3), .RA_W(5), .FWD_EN(0), .LOAD_LAT(1), .RESOLVE_STAGE(3),
                       .RF_WB_BYPASS(1), .CNT_W(32)) dutC (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
        .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used), .id_wr(idWr), .id_we(idWe),
        .id_is_load(idIsLoad), .redirect_valid(redirectValid), .stall_if_id(stallC),
        .bubble_ex(bubbleC), .flush_if_id(flushC), .kill_mask(killC), .fwd_sel_a(selAC),
        .fwd_sel_b(selBC), .stall_cnt(stallCntC), .flush_cnt(flushCntC));

    pipe_hazard_ctrl #(.DEPTH(3), .RA_W(5), .FWD_EN(0), .LOAD_LAT(1), .RESOLVE_STAGE(3),
                       .RF_WB_BYPASS(0), .CNT_W(4)) dutD (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
        .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used), .id_wr(idWr), .id_we(idWe),
        .id_is_load(idIsLoad), .redirect_valid(redirectValid), .stall_if_id(stallD),
        .bubble_ex(bubbleD), .flush_if_id(flushD), .kill_mask(killD), .fwd_sel_a(selAD),
        .fwd_sel_b(selBD), .stall_cnt(stallCntD), .flush_cnt(flushCntD));

    // Advance to just after the next rising edge; inputs change here, checks follow #2 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] wr,
                         input logic we, input logic ld);
        idValid   = v;
        idRs1     = rs1;
        idRs1Used = u1;
        idRs2     = rs2;
        idRs2Used = u2;
        idWr      = wr;
        idWe      = we;
        idIsLoad  = ld;
    endtask

    task automatic doReset();
        rst_n         = 1'b0;
        redirectValid = 1'b0;
        setId(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        #2;
        checks++; if (stallA !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%0b exp=0", stallA); end
        checks++; if (bubbleA !== 1'b0) begin errors++; $display("[TB] FAIL reset_bubble got=%0b exp=0", bubbleA); end
        checks++; if (flushA !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush got=%0b exp=0", flushA); end
        checks++; if (killA !== 3'b000) begin errors++; $display("[TB] FAIL reset_kill got=%b exp=000", killA); end
        checks++; if (selAA !== 4'd0 || selBA !== 4'd0) begin errors++; $display("[TB] FAIL reset_fwd got=%0d/%0d exp=0/0", selAA, selBA); end
        checks++; if (stallCntA !== 32'd0 || flushCntA !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", stallCntA, flushCntA); end
        checks++; if (stallB !== 1'b0 || stallD !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_interlock got=%0b/%0b exp=0/0", stallB, stallD); end
    endtask

    task automatic test_alu_back_to_back();
        doReset();
        setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        #2;
        checks++; if (stallA !== 1'b0) begin errors++; $display("[TB] FAIL alu_producer_stall got=%0b exp=0", stallA); end
        tick();
        setId(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        #2;
        checks++; if (selAA !== 4'd1) begin errors++; $display("[TB] FAIL alu_fwd_sel_a got=%0d exp=1", selAA); end
        checks++; if (stallA !== 1'b0 || bubbleA !== 1'b0) begin errors++; $display("[TB] FAIL alu_no_stall got=%0b/%0b exp=0/0", stallA, bubbleA); end
        tick();
        setId(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        checks++; if (stallCntA !== 32'd0) begin errors++; $display("[TB] FAIL alu_stall_cnt got=%0d exp=0", stallCntA); end
    endtask

    task automatic test_load_use();
        doReset();
        setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        setId(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0);
        #2;
        checks++; if (stallA !== 1'b1 || bubbleA !== 1'b1) begin errors++; $display("[TB] FAIL loaduse_stall got=%0b/%0b exp=1/1", stallA, bubbleA); end
        checks++; if (stallCntA !== 32'd0) begin errors++; $display("[TB] FAIL loaduse_cnt_pre got=%0d exp=0", stallCntA); end
        tick();
        #2;
        checks++; if (stallA !== 1'b0 || bubbleA !== 1'b0) begin errors++; $display("[TB] FAIL loaduse_release got=%0b/%0b exp=0/0", stallA, bubbleA); end
        checks++; if (selBA !== 4'd2) begin errors++; $display("[TB] FAIL loaduse_fwd_sel_b got=%0d exp=2", selBA); end
        checks++; if (stallCntA !== 32'd1) begin errors++; $display("[TB] FAIL loaduse_cnt got=%0d exp=1", stallCntA); end
    endtask

    task automatic test_x0_and_youngest();
        doReset();
        setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        #2;
        checks++; if (stallA !== 1'b0 || selAA !== 4'd0) begin errors++; $display("[TB] FAIL x0_no_match got=%0b/%0d exp=0/0", stallA, selAA); end
        tick();
        setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd10, 1'b1, 1'b0);
        #2;
        checks++; if (selAA !== 4'd1 || selBA !== 4'd1) begin errors++; $display("[TB] FAIL youngest_sel got=%0d/%0d exp=1/1", selAA, selBA); end
        checks++; if (stallA !== 1'b0) begin errors++; $display("[TB] FAIL youngest_stall got=%0b exp=0", stallA); end
        tick();
        setId(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        #2;
        checks++; if (selAA !== 4'd2) begin errors++; $display("[TB] FAIL slot2_sel got=%0d exp=2", selAA); end
    endtask

    task automatic test_redirect_beats_stall();
        doReset();
        setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        setId(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0);
        redirectValid = 1'b1;
        #2;
        checks++; if (stallA !== 1'b0) begin errors++; $display("[TB] FAIL redir_stall got=%0b exp=0", stallA); end
        checks++; if (flushA !== 1'b1 || bubbleA !== 1'b1) begin errors++; $display("[TB] FAIL redir_flush_bubble got=%0b/%0b exp=1/1", flushA, bubbleA); end
        checks++; if (killA !== 3'b011) begin errors++; $display("[TB] FAIL redir_kill got=%b exp=011", killA); end
        tick();
        redirectValid = 1'b0;
        #2;
        checks++; if (flushCntA !== 32'd1) begin errors++; $display("[TB] FAIL redir_flush_cnt got=%0d exp=1", flushCntA); end
        checks++; if (stallCntA !== 32'd0) begin errors++; $display("[TB] FAIL redir_stall_cnt got=%0d exp=0", stallCntA); end
        checks++; if (selBA !== 4'd0 || stallA !== 1'b0) begin errors++; $display("[TB] FAIL redir_load_killed got=%0d/%0b exp=0/0", selBA, stallA); end
        checks++; if (killA !== 3'b000 || flushA !== 1'b0) begin errors++; $display("[TB] FAIL redir_idle got=%b/%0b exp=000/0", killA, flushA); end
    endtask

    task automatic test_interlock();
        int relB = -1;
        int relC = -1;
        logic [3:0] selAtRelB = 4'hF;
        doReset();
        setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #2;
            if (!stallB && relB < 0) begin relB = i; selAtRelB = selAB; end
            if (!stallC && relC < 0) relC = i;
            tick();
        end
        setId(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        checks++; if (relB != 3) begin errors++; $display("[TB] FAIL interlock_stall_cycles got=%0d exp=3", relB); end
        checks++; if (selAtRelB !== 4'd0) begin errors++; $display("[TB] FAIL interlock_fwd_sel got=%0d exp=0", selAtRelB); end
        checks++; if (stallCntB !== 32'd3) begin errors++; $display("[TB] FAIL interlock_cnt got=%0d exp=3", stallCntB); end
        checks++; if (relC != 2) begin errors++; $display("[TB] FAIL wbbypass_stall_cycles got=%0d exp=2", relC); end
        checks++; if (stallCntC !== 32'd2) begin errors++; $display("[TB] FAIL wbbypass_cnt got=%0d exp=2", stallCntC); end
    endtask

    task automatic test_reset_mid_stall();
        doReset();
        setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        setId(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0);
        #2;
        checks++; if (stallA !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_stall got=%0b exp=1", stallA); end
        rst_n = 1'b0;
        tick();
        #2;
        checks++; if (stallA !== 1'b0 || bubbleA !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stall got=%0b/%0b exp=0/0", stallA, bubbleA); end
        checks++; if (flushA !== 1'b0 || killA !== 3'b000) begin errors++; $display("[TB] FAIL midrst_flush got=%0b/%b exp=0/000", flushA, killA); end
        checks++; if (selAA !== 4'd0 || selBA !== 4'd0) begin errors++; $display("[TB] FAIL midrst_fwd got=%0d/%0d exp=0/0", selAA, selBA); end
        checks++; if (stallCntA !== 32'd0) begin errors++; $display("[TB] FAIL midrst_cnt got=%0d exp=0", stallCntA); end
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        doReset();
        // Self-dependent instruction held in ID: interlock gives 3 stalls per 4 cycles.
        setId(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        #2;
        checks++; if (stallCntD !== 4'd9) begin errors++; $display("[TB] FAIL sat_stall_mid got=%0d exp=9", stallCntD); end
        for (int i = 0; i < 12; i++) tick();
        #2;
        checks++; if (stallCntD !== 4'd15) begin errors++; $display("[TB] FAIL sat_stall_hold got=%0d exp=15", stallCntD); end
        doReset();
        redirectValid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        redirectValid = 1'b0;
        #2;
        checks++; if (flushCntD !== 4'd15) begin errors++; $display("[TB] FAIL sat_flush got=%0d exp=15", flushCntD); end
        checks++; if (flushCntA !== 32'd20) begin errors++; $display("[TB] FAIL flush_cnt_wide got=%0d exp=20", flushCntA); end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_x0_and_youngest();
        test_redirect_beats_stall();
        test_interlock();
        test_reset_mid_stall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard/interlock controller for the in-order RISC-V pipeline: IF, ID, then DEPTH back-end stages, where slot 1 is EX and slot DEPTH is WB.
- Keeps a shadow tag pipeline of in-flight destination registers. From it, it generates IF/ID stall, EX bubble insertion, branch/jump flush masks and per-operand forwarding selects.
- Mode parameter selects full forwarding or interlock-only operation.
- Also keeps stall/flush performance counters.

Parameters:
- DEPTH, 3: back-end slots after ID (EX..WB); legal 2..8.
- RA_W, 5: register address width.
- FWD_EN, 1: 1 = forwarding mode; 0 = interlock-only mode.
- LOAD_LAT, 1: a load result is forwardable only from slot k > LOAD_LAT; legal 1..DEPTH-1.
- RESOLVE_STAGE, 3: slot in which redirect_valid is raised; legal 1..DEPTH.
- RF_WB_BYPASS, 0: 1 = register file is write-through, so a producer in slot DEPTH causes no hazard.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  RA_W each  ID source registers.
- id_rs1_used, id_rs2_used  in  1 each  source is actually read.
- id_wr  in  RA_W  ID destination register.
- id_we  in  1  ID instruction writes the register file.
- id_is_load  in  1  ID instruction is a load.
- redirect_valid  in  1  taken branch/jump resolved in RESOLVE_STAGE this cycle.
- stall_if_id  out  1  hold PC and the IF/ID register.
- bubble_ex  out  1  load a NOP into the ID->EX register.
- flush_if_id  out  1  invalidate the IF/ID register.
- kill_mask  out  DEPTH  bit k-1 set = squash slot k at the next edge.
- fwd_sel_a, fwd_sel_b  out  4  0 = register file; k = slot k result.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Tag slot k (1..DEPTH) holds {v, we, wr, ld}.
- Every edge, all slots shift: slot k <= slot k-1. Back-end slots never stall.
- Slot 1 <= ID tag when issue = id_valid & ~stall_if_id & ~redirect_valid; otherwise slot 1 <= bubble (v=0).
- On the same edge, any slot whose kill_mask bit is set is written v=0 after the shift.
- Match(rs, k): rs_used & rs != 0 & slot k v & we & wr == rs. x0 never matches.
- For each source, take the youngest match, i.e. the smallest k.
- FWD_EN=1:
  - fwd_sel = k if the youngest match is forwardable: non-load any k, load k > LOAD_LAT.
  - A load with k <= LOAD_LAT is a hazard.
  - No match gives fwd_sel = 0.
  - A match at k = DEPTH with RF_WB_BYPASS=1 gives fwd_sel = 0.
- FWD_EN=0:
  - fwd_sel is always 0.
  - A hazard exists if any match has k < DEPTH, or k = DEPTH with RF_WB_BYPASS=0.
- hazard = id_valid & (hazard on rs1 | hazard on rs2).
- stall_if_id = hazard & ~redirect_valid. Redirect wins over stall.
- bubble_ex = stall_if_id | redirect_valid.
- redirect_valid:
  - flush_if_id = 1.
  - kill_mask bits for slots 1..RESOLVE_STAGE-1 are set, so all younger back-end instructions are squashed.
  - The resolving slot itself and older slots survive.
  - RESOLVE_STAGE=1 gives kill_mask = 0.
- stall_if_id, bubble_ex, flush_if_id, kill_mask and fwd_sel are combinational from registered tags and current ID inputs. There is no added latency.
- stall_cnt increments on every cycle with stall_if_id = 1. flush_cnt increments on every redirect_valid cycle. Both saturate at all-ones and do not wrap.
- Synchronous reset with rst_n = 0 at an edge:
  - all slots v=0 and counters 0.
  - With all slots invalid, stall_if_id, bubble_ex, flush_if_id and kill_mask are 0 and fwd_sel is 0, as long as redirect_valid = 0.
  - Reset mid-stall releases the stall on the next cycle.
- A multi-cycle load-use stall repeats each cycle until the load reaches slot LOAD_LAT+1. Tags keep shifting during the stall, so the stall self-terminates.

Test Plan:
- Defaults apply unless stated (DEPTH=3, FWD_EN=1, LOAD_LAT=1).
- ALU back-to-back: add x5 issued, next cycle ID rs1=x5 -> fwd_sel_a=1, stall_if_id=0, stall_cnt unchanged.
- Load-use: lw x6 issued, next ID rs2=x6 -> stall_if_id=1 and bubble_ex=1 for exactly 1 cycle; then fwd_sel_b=2; stall_cnt=1.
- x0 and multiple matches: producer writes x0 with rs1=x0 -> no stall, fwd_sel_a=0. x7 written in slots 1 and 2 -> fwd_sel=1 (youngest).
- Redirect beats stall: load-use hazard and redirect_valid in the same cycle with RESOLVE_STAGE=3 -> stall_if_id=0, flush_if_id=1, bubble_ex=1, kill_mask=3'b011, flush_cnt=1.
- Interlock mode (FWD_EN=0, RF_WB_BYPASS=0): dependent instruction directly after its producer -> stall for 3 cycles, then fwd_sel=0 and issue. With RF_WB_BYPASS=1 -> stall for 2 cycles.
- Reset and saturation: assert rst_n=0 during a stall -> next cycle all outputs 0. Force counters near all-ones with CNT_W=4 -> stall_cnt holds at 15.
